serial_adder_subtractor: RTL and testbench
==========================================

Name: serial_adder_subtractor

Overview:
Multi-cycle, digit-serial successor to the combinational N-bit adder-subtractor. It adds or subtracts two N-bit two's-complement operands K bits per clock, using a start/done handshake. It also reports unsigned carry/borrow and signed overflow. It is intended for area-constrained datapaths where a full-width carry chain is too costly.

Parameters:
N, 8, operand/result width in bits; N >= 2.
K, 1, digit width processed per cycle; 1 <= K <= N and N mod K = 0 (elaboration error otherwise).

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
Start  input  1  request; sampled only in IDLE.
A  input  N  operand A, two's complement; sampled at the accepting edge only.
B  input  N  operand B, two's complement; sampled at the accepting edge only.
Op  input  1  0 = A+B, 1 = A-B; sampled at the accepting edge only.
Busy  output  1  high while in RUN.
Done  output  1  one-cycle pulse; results are valid from this cycle.
S  output  N  result, A±B mod 2^N.
Cout  output  1  carry out of the MSB; for subtraction, 1 = no borrow (A >= B unsigned).
Ovf  output  1  signed overflow.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset:
  - state = IDLE; Busy = 0; Done = 0; S = 0; Cout = 0; Ovf = 0.
  - Internal shift registers, carry and digit counter are cleared.
  - Reset has priority over everything, including mid-RUN; any partial result is discarded.
- IDLE, Start=1 at edge t:
  - Load the A shift register with A and the Bx shift register with B XOR {N{Op}}.
  - carry = Op; counter = 0.
  - Latch the MSBs A[N-1] and Bx[N-1] for the overflow calculation.
  - Go to RUN.
- IDLE, Start=0: hold all state. S, Cout and Ovf keep their last values.
- RUN, each cycle:
  - sum = Ashift[K-1:0] + Bxshift[K-1:0] + carry, computed K+1 bits wide.
  - The low K bits shift into the top of the S accumulator (LSB digit first, right shift by K).
  - carry = sum[K]; counter increments.
  - After N/K RUN cycles, go to DONE.
  - S, Cout and Ovf update only on the final RUN edge. S is never exposed partially; a separate accumulator feeds the S register.
- DONE: Done = 1 for exactly one cycle, then go to IDLE.
- Latency: Start accepted at edge t → Busy high for cycles t+1 .. t+N/K → Done high in cycle t+N/K+1. Total of N/K+1 cycles from the Start cycle to the Done cycle.
- Back-to-back: Start high during DONE is ignored. The earliest next acceptance is the IDLE cycle after DONE.
- Start while Busy or Done is ignored. A, B and Op may change freely after acceptance with no effect.
- Result flags:
  - Cout = final carry.
  - Ovf = (A[N-1] == Bx[N-1]) AND (S[N-1] != A[N-1]), using the latched MSBs.
- K = N degenerates to 1 RUN cycle (latency 2) and must be supported.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- N=4, K=1. A=0010, B=0001, Op=0 → S=0011, Cout=0, Ovf=0. Busy high for 4 cycles; Done 5 cycles after the Start cycle.
- N=4, K=1, back-to-back, with Start held high through DONE and pulsed again on the first IDLE cycle:
  - A=1110, B=0011, Op=0 → S=0001, Cout=1, Ovf=0.
  - Then A=0111, B=0011, Op=1 → S=0100, Cout=1, Ovf=0.
  - Start during DONE must not trigger a third operation.
- N=4, K=1, subtraction and overflow:
  - A=1100, B=0100, Op=1 → S=1000, Cout=1, Ovf=0.
  - A=0001, B=0011, Op=1 → S=1110, Cout=0, Ovf=0.
  - A=0111, B=0010, Op=0 → S=1001, Cout=0, Ovf=1.
- N=8, K=2: A=0x7F, B=0x01, Op=0 → S=0x80, Cout=0, Ovf=1; Done 5 cycles after Start. Then A=0xFF, B=0xFF, Op=0 → S=0xFE, Cout=1, Ovf=0.
- Start held high while Busy, with A and B changed mid-RUN → the result reflects the originally latched operands and there is exactly one Done pulse.
- Reset mid-RUN (N=8, K=1, rst at RUN cycle 3) → the next cycle has Busy=0, Done=0, S=0, Cout=0, Ovf=0 in IDLE, and a following Start computes correctly.

Source files
------------

// File: rtl/serial_adder_subtractor.sv
// Digit-serial two's-complement adder/subtractor.
// Processes K bits per clock; start/done handshake with carry and overflow flags.
module serial_adder_subtractor #(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Op,
    output logic         Busy,
    output logic         Done,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         Ovf
);

    if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
        $error("serial_adder_subtractor: illegal N/K combination");
    end

    localparam int STEPS = N / K;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [N-1:0]   ash;
    logic [N-1:0]   bsh;
    logic [N-1:0]   acc;
    logic [N-1:0]   acc_nx;
    logic [N-1:0]   bx;
    logic           carry;
    logic           amsb;
    logic           bmsb;
    logic [CW-1:0]  cnt;
    logic           last;
    logic [K:0]     sum;

    assign bx   = B ^ {N{Op}};
    assign last = (cnt == CW'(STEPS - 1));

    // One digit of the ripple: low digits of both shifters plus carry.
    always_comb begin
        sum    = {1'b0, ash[K-1:0]} + {1'b0, bsh[K-1:0]} + {{K{1'b0}}, carry};
        acc_nx = (acc >> K) | (N'(sum[K-1:0]) << (N - K));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; Start only matters in IDLE.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (Start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from the state register only.
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        unique case (state)
            RUN:     Busy = 1'b1;
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: load on accept, shift per digit, publish results on the last digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ash   <= '0;
            bsh   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            amsb  <= 1'b0;
            bmsb  <= 1'b0;
            cnt   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            Ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        ash   <= A;
                        bsh   <= bx;
                        carry <= Op;
                        cnt   <= '0;
                        amsb  <= A[N-1];
                        bmsb  <= bx[N-1];
                    end
                end
                RUN: begin
                    ash   <= ash >> K;
                    bsh   <= bsh >> K;
                    acc   <= acc_nx;
                    carry <= sum[K];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        S    <= acc_nx;
                        Cout <= sum[K];
                        Ovf  <= (amsb == bmsb) && (acc_nx[N-1] != amsb);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Bench for serial_adder_subtractor across several N/K shapes.
// Scoreboard queue filled at accept time, drained on each Done pulse.
module tb_serial_adder_subtractor;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         due;
        int         steps;
    } exp_t;

    typedef struct {
        int         sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       op;
    int         sel;
    int         cyc;

    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] cout_v;
    logic [3:0] ovf_v;
    logic [3:0] s4;
    logic [7:0] s82;
    logic [7:0] s81;
    logic [7:0] s88;

    logic [7:0] s_m;
    logic       busy_m;
    logic       done_m;
    logic       cout_m;
    logic       ovf_m;

    exp_t sb[$];
    exp_t e;
    int   checks;
    int   errors;
    int   ndone;
    int   npush;
    int   bcnt;

    serial_adder_subtractor #(.N(4), .K(1)) u_n4k1 (
        .clk(clk), .rst(rst), .Start(start && sel == 0),
        .A(a[3:0]), .B(b[3:0]), .Op(op),
        .Busy(busy_v[0]), .Done(done_v[0]), .S(s4),
        .Cout(cout_v[0]), .Ovf(ovf_v[0])
    );

    serial_adder_subtractor #(.N(8), .K(2)) u_n8k2 (
        .clk(clk), .rst(rst), .Start(start && sel == 1),
        .A(a), .B(b), .Op(op),
        .Busy(busy_v[1]), .Done(done_v[1]), .S(s82),
        .Cout(cout_v[1]), .Ovf(ovf_v[1])
    );

    serial_adder_subtractor #(.N(8), .K(1)) u_n8k1 (
        .clk(clk), .rst(rst), .Start(start && sel == 2),
        .A(a), .B(b), .Op(op),
        .Busy(busy_v[2]), .Done(done_v[2]), .S(s81),
        .Cout(cout_v[2]), .Ovf(ovf_v[2])
    );

    serial_adder_subtractor #(.N(8), .K(8)) u_n8k8 (
        .clk(clk), .rst(rst), .Start(start && sel == 3),
        .A(a), .B(b), .Op(op),
        .Busy(busy_v[3]), .Done(done_v[3]), .S(s88),
        .Cout(cout_v[3]), .Ovf(ovf_v[3])
    );

    always_comb begin
        s_m    = 8'h00;
        busy_m = busy_v[sel[1:0]];
        done_m = done_v[sel[1:0]];
        cout_m = cout_v[sel[1:0]];
        ovf_m  = ovf_v[sel[1:0]];
        case (sel)
            0:       s_m = {4'h0, s4};
            1:       s_m = s82;
            2:       s_m = s81;
            default: s_m = s88;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int steps(input int s_);
        case (s_)
            0:       return 4;
            1:       return 4;
            2:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic exp_t model(input int s_, input logic [7:0] a_,
                                   input logic [7:0] b_, input logic op_);
        exp_t       r;
        int         w;
        logic [8:0] mask;
        logic [8:0] am;
        logic [8:0] bx;
        logic [8:0] t;
        w    = (s_ == 0) ? 4 : 8;
        mask = 9'((1 << w) - 1);
        am   = {1'b0, a_} & mask;
        bx   = {1'b0, b_ ^ {8{op_}}} & mask;
        t    = am + bx + {8'h00, op_};
        r.s  = t[7:0] & mask[7:0];
        r.c  = t[w];
        r.o  = (am[w-1] == bx[w-1]) && (t[w-1] != am[w-1]);
        r.due   = 0;
        r.steps = 0;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (sel %0d, cycle %0d)",
                     nm, act, exp_v, sel, cyc);
        end
    endtask

    // Compares each Done pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (busy_m) bcnt++;
        if (rst) bcnt = 0;
        if (done_m) begin
            ndone++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("S", int'(s_m), int'(e.s));
                chk("Cout", int'(cout_m), int'(e.c));
                chk("Ovf", int'(ovf_m), int'(e.o));
                chk("done_cycle", cyc, e.due);
                chk("busy_cycles", bcnt, e.steps);
            end
            bcnt = 0;
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        sb.delete();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_m && !done_m) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: got busy %0b expected 0", busy_m);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_m) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: got no Done expected a pulse");
    endtask

    task automatic go(input int s_, input logic [7:0] a_, input logic [7:0] b_,
                      input logic op_, input logic [7:0] es, input logic ec,
                      input logic eo, input bit hold);
        exp_t x;
        wait_drain();
        sel = s_;
        wait_idle();
        a     = a_;
        b     = b_;
        op    = op_;
        start = 1'b1;
        @(posedge clk);
        #1;
        x.s     = es;
        x.c     = ec;
        x.o     = eo;
        x.due   = cyc + steps(s_);
        x.steps = steps(s_);
        sb.push_back(x);
        npush++;
        if (!hold) start = 1'b0;
    endtask

    vec_t tbl[9];
    exp_t m;

    initial begin
        checks = 0;
        errors = 0;
        ndone  = 0;
        npush  = 0;
        bcnt   = 0;
        sel    = 0;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        op     = 1'b0;
        rst    = 1'b1;

        tbl[0] = '{0, 8'h02, 8'h01, 1'b0, 8'h03, 1'b0, 1'b0};
        tbl[1] = '{0, 8'h0C, 8'h04, 1'b1, 8'h08, 1'b1, 1'b0};
        tbl[2] = '{0, 8'h01, 8'h03, 1'b1, 8'h0E, 1'b0, 1'b0};
        tbl[3] = '{0, 8'h07, 8'h02, 1'b0, 8'h09, 1'b0, 1'b1};
        tbl[4] = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[5] = '{1, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0};
        tbl[6] = '{2, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[7] = '{3, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[8] = '{3, 8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1;
            chk("rst_busy", int'(busy_m), 0);
            chk("rst_done", int'(done_m), 0);
            chk("rst_S", int'(s_m), 0);
            chk("rst_Cout", int'(cout_m), 0);
            chk("rst_Ovf", int'(ovf_m), 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            go(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].op,
               tbl[i].es, tbl[i].ec, tbl[i].eo, 1'b0);
        end

        // Back-to-back on N=4: Start held through RUN and DONE, operands
        // swapped mid-run; the first IDLE edge takes the second operation.
        go(0, 8'h0E, 8'h03, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
        a  = 8'h07;
        b  = 8'h03;
        op = 1'b1;
        wait_done();
        @(posedge clk);
        @(posedge clk);
        #1;
        m.s     = 8'h04;
        m.c     = 1'b1;
        m.o     = 1'b0;
        m.due   = cyc + 4;
        m.steps = 4;
        sb.push_back(m);
        npush++;
        start = 1'b0;
        wait_drain();
        repeat (10) @(negedge clk);

        // Start held while busy on N=8 K=2, operands changed mid-run.
        go(1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        a  = 8'h11;
        b  = 8'h22;
        op = 1'b1;
        wait_done();
        start = 1'b0;
        wait_drain();
        repeat (6) @(negedge clk);

        // Reset during the third RUN cycle discards the operation.
        go(2, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b0);
        go(2, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        npush--;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", int'(busy_m), 0);
        chk("midrst_done", int'(done_m), 0);
        chk("midrst_S", int'(s_m), 0);
        chk("midrst_Cout", int'(cout_m), 0);
        chk("midrst_Ovf", int'(ovf_m), 0);
        rst = 1'b0;
        go(2, 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0, 1'b0);

        for (int s_ = 0; s_ < 4; s_++) begin
            for (int i = 0; i < 6; i++) begin
                logic [7:0] ra;
                logic [7:0] rb;
                logic       ro;
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                ro = 1'($urandom_range(0, 1));
                m  = model(s_, ra, rb, ro);
                go(s_, ra, rb, ro, m.s, m.c, m.o, 1'b0);
            end
        end

        wait_drain();
        repeat (4) @(negedge clk);
        chk("done_count", ndone, npush);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
